// File: rtl/rst_seq_gen.sv
// Multi-channel reset sequencer: releases CHANNELS reset domains in ascending
// order after a hold time, supports soft re-sequencing and a divided clock enable.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_HOLD    | all channels in reset, counting the hold time to channel 0
// S_RELEASE | channels 0..idx-1 released, counting the step to channel idx
// S_DONE    | all channels released; a soft request restarts the sequence
module rst_seq_gen #(
   parameter int CHANNELS    = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int STEP_CYCLES = 8,
   parameter int CLKEN_DIV   = 4
) (
   input  logic                clk,
   input  logic                srst,
   input  logic                soft_req,
   output logic                soft_ack,
   output logic [CHANNELS-1:0] ch_srst,
   output logic [CHANNELS-1:0] ch_srstn,
   output logic                seq_done,
   output logic                clk_en
);

   localparam int MAX_HS = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
   localparam int MAX_C  = (MAX_HS > CLKEN_DIV) ? MAX_HS : CLKEN_DIV;
   localparam int CW     = $clog2(MAX_C + 1);
   localparam int IW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] STEP_TC = CW'(STEP_CYCLES - 1);
   localparam logic [CW-1:0] DIV_TC  = CW'(CLKEN_DIV - 1);
   localparam logic [IW-1:0] LAST_CH = IW'(CHANNELS - 1);

   typedef enum logic [1:0] {
      S_HOLD,
      S_RELEASE,
      S_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [CW-1:0] div_cnt;

   // Release order is strictly ascending, so the reset vector is a left shift
   // that pulls one more zero in from the bottom at each release.
   always_ff @(posedge clk) begin
      if (srst) begin
         state    <= S_HOLD;
         cnt      <= '0;
         idx      <= '0;
         ch_srst  <= '1;
         ch_srstn <= '0;
         seq_done <= 1'b0;
         soft_ack <= 1'b0;
      end else begin
         soft_ack <= 1'b0;
         case (state)
            S_HOLD: begin
               if (cnt == HOLD_TC) begin
                  cnt      <= '0;
                  ch_srst  <= ch_srst << 1;
                  ch_srstn <= ~(ch_srst << 1);
                  if (CHANNELS == 1) begin
                     state    <= S_DONE;
                     seq_done <= 1'b1;
                  end else begin
                     state <= S_RELEASE;
                     idx   <= IW'(1);
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RELEASE: begin
               if (cnt == STEP_TC) begin
                  cnt      <= '0;
                  ch_srst  <= ch_srst << 1;
                  ch_srstn <= ~(ch_srst << 1);
                  if (idx == LAST_CH) begin
                     state    <= S_DONE;
                     seq_done <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (soft_req) begin
                  state    <= S_HOLD;
                  cnt      <= '0;
                  idx      <= '0;
                  ch_srst  <= '1;
                  ch_srstn <= '0;
                  seq_done <= 1'b0;
                  soft_ack <= 1'b1;
               end
            end
            default: begin
               state    <= S_HOLD;
               cnt      <= '0;
               idx      <= '0;
               ch_srst  <= '1;
               ch_srstn <= '0;
               seq_done <= 1'b0;
            end
         endcase
      end
   end

   // Free-running divider; only srst touches it, the FSM never does.
   always_ff @(posedge clk) begin
      if (srst) begin
         div_cnt <= '0;
         clk_en  <= 1'b0;
      end else if (div_cnt == DIV_TC) begin
         div_cnt <= '0;
         clk_en  <= 1'b1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
         clk_en  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: default instance plus a single-channel, fast instance,
// both checked every cycle against an elapsed-time model of the release schedule.
module tb_rst_seq_gen;

   logic       clk = 1'b0;
   logic       srst;
   logic       soft_req;

   logic       soft_ack, seq_done, clk_en;
   logic [3:0] ch_srst, ch_srstn;
   logic       a1_ack, a1_done, a1_en;
   logic [0:0] a1_rst, a1_rstn;

   always #5 clk = ~clk;

   rst_seq_gen dut (
      .clk      (clk),
      .srst     (srst),
      .soft_req (soft_req),
      .soft_ack (soft_ack),
      .ch_srst  (ch_srst),
      .ch_srstn (ch_srstn),
      .seq_done (seq_done),
      .clk_en   (clk_en)
   );

   rst_seq_gen #(.CHANNELS(1), .HOLD_CYCLES(1), .STEP_CYCLES(8), .CLKEN_DIV(1)) dut1 (
      .clk      (clk),
      .srst     (srst),
      .soft_req (soft_req),
      .soft_ack (a1_ack),
      .ch_srst  (a1_rst),
      .ch_srstn (a1_rstn),
      .seq_done (a1_done),
      .clk_en   (a1_en)
   );

   int vectors     = 0;
   int miscompares = 0;

   int p_ch[2]   = '{4, 1};
   int p_hold[2] = '{16, 1};
   int p_step[2] = '{8, 8};
   int p_div[2]  = '{4, 1};

   // k: edges since sequence origin, m: edges since srst deassertion
   int         k[2];
   int         m[2];
   logic [3:0] e_rst[2];
   logic       e_done[2], e_ack[2], e_en[2];

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      for (int j = 0; j < 2; j++) begin
         if (srst) begin
            k[j] = 0; m[j] = 0;
            e_rst[j] = 4'hF; e_done[j] = 1'b0; e_ack[j] = 1'b0; e_en[j] = 1'b0;
         end else begin
            int t_done;
            t_done = p_hold[j] + (p_ch[j] - 1) * p_step[j];
            m[j]++;
            e_en[j] = ((m[j] % p_div[j]) == 0);
            if (k[j] >= t_done && soft_req) begin
               k[j] = 0;
               e_ack[j] = 1'b1; e_rst[j] = 4'hF; e_done[j] = 1'b0;
            end else begin
               k[j]++;
               e_ack[j]  = 1'b0;
               e_done[j] = (k[j] >= t_done);
               e_rst[j]  = 4'hF;
               for (int i = 0; i < p_ch[j]; i++)
                  e_rst[j][i] = (k[j] < p_hold[j] + i * p_step[j]);
            end
         end
      end
      #1;
      chk("ch_srst",  ch_srst,  e_rst[0]);
      chk("ch_srstn", ch_srstn, ~e_rst[0]);
      chk("seq_done", {3'b0, seq_done}, {3'b0, e_done[0]});
      chk("soft_ack", {3'b0, soft_ack}, {3'b0, e_ack[0]});
      chk("clk_en",   {3'b0, clk_en},   {3'b0, e_en[0]});
      chk("c1_ch_srst",  {3'b0, a1_rst},  {3'b0, e_rst[1][0]});
      chk("c1_ch_srstn", {3'b0, a1_rstn}, {3'b0, ~e_rst[1][0]});
      chk("c1_seq_done", {3'b0, a1_done}, {3'b0, e_done[1]});
      chk("c1_soft_ack", {3'b0, a1_ack},  {3'b0, e_ack[1]});
      chk("c1_clk_en",   {3'b0, a1_en},   {3'b0, e_en[1]});
   end

   int ed;

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         ed++;
      end
   endtask

   task automatic do_reset(input int n);
      srst = 1'b1;
      repeat (n) @(negedge clk);
      srst = 1'b0;
      ed = 0;
   endtask

   initial begin
      int mode;
      srst = 1'b1;
      soft_req = 1'b0;
      ed = 0;

      // initial release schedule
      do_reset(5);
      step(15); chk("lit_hold15", ch_srst, 4'hF);
      step(1);  chk("lit_rel16",  ch_srst, 4'b1110);
      step(8);  chk("lit_rel24",  ch_srst, 4'b1100);
      step(8);  chk("lit_rel32",  ch_srst, 4'b1000);
      step(7);  chk("lit_done39", {3'b0, seq_done}, 4'h0);
      step(1);  chk("lit_rel40",  ch_srst, 4'b0000);
                chk("lit_done40", {3'b0, seq_done}, 4'h1);

      // soft request accepted in DONE
      step(9); soft_req = 1'b1;
      step(1); chk("lit_ack50", {3'b0, soft_ack}, 4'h1);
               chk("lit_rst50", ch_srst, 4'hF);
               chk("lit_sd50",  {3'b0, seq_done}, 4'h0);
      soft_req = 1'b0;
      step(1);  chk("lit_ack51", {3'b0, soft_ack}, 4'h0);
      step(14); chk("lit_hold65", ch_srst, 4'hF);
      step(1);  chk("lit_rel66",  ch_srst, 4'b1110);
      step(24); chk("lit_rel90",  ch_srst, 4'b0000);

      // soft request during RELEASE is ignored, then srst mid-sequence
      do_reset(3);
      step(19); soft_req = 1'b1;
      step(1);  chk("lit_noack20", {3'b0, soft_ack}, 4'h0);
      soft_req = 1'b0;
      step(4);  chk("lit_rel24b", ch_srst, 4'b1100);
      step(3);  srst = 1'b1;
      step(1);  chk("lit_srst28", ch_srst, 4'hF);
                chk("lit_sd28",   {3'b0, seq_done}, 4'h0);
      repeat (2) @(negedge clk);
      srst = 1'b0; ed = 0;
      step(1);  chk("lit_c1_rel1", {3'b0, a1_rst},  4'h0);
                chk("lit_c1_sd1",  {3'b0, a1_done}, 4'h1);
                chk("lit_c1_en1",  {3'b0, a1_en},   4'h1);
      step(15); chk("lit_rel16c", ch_srst, 4'b1110);
      step(24); chk("lit_rel40c", ch_srst, 4'b0000);

      // soft request held high: back-to-back sequences
      step(4);  chk("lit_en44", {3'b0, clk_en}, 4'h1);
      soft_req = 1'b1;
      step(1);  chk("lit_ack45", {3'b0, soft_ack}, 4'h1);
                chk("lit_en45",  {3'b0, clk_en},   4'h0);
      step(1);  chk("lit_ack46", {3'b0, soft_ack}, 4'h0);
      step(39); chk("lit_ack85", {3'b0, soft_ack}, 4'h0);
                chk("lit_rel85", ch_srst, 4'b0000);
      step(1);  chk("lit_ack86", {3'b0, soft_ack}, 4'h1);
                chk("lit_rst86", ch_srst, 4'hF);
      soft_req = 1'b0;

      // randomized traffic in blocks with different request densities
      for (int b = 0; b < 16; b++) begin
         mode = int'($urandom_range(2));
         repeat (200) begin
            @(negedge clk);
            srst = ($urandom_range(999) < 8);
            case (mode)
               0:       soft_req = ($urandom_range(99) < 5);
               1:       soft_req = ($urandom_range(99) < 30);
               default: soft_req = ($urandom_range(99) < 95);
            endcase
         end
      end
      srst = 1'b0;
      soft_req = 1'b0;
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
